// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access pipeline stage: operation/size codes,
// FSM states and the store-side lane helpers.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr);
        logic res;
        case (size)
            SIZE_BYTE: res = 1'b0;
            SIZE_HALF: res = addr[0];
            default:   res = (addr != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_strobe(input mem_size_e size, input logic [1:0] addr);
        logic [3:0] res;
        case (size)
            SIZE_BYTE: res = 4'b0001 << addr;
            SIZE_HALF: res = 4'b0011 << {addr[1], 1'b0};
            default:   res = 4'b1111;
        endcase
        return res;
    endfunction

    // The memory picks the lane via the strobe, so the data is replicated everywhere.
    function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = {4{data[7:0]}};
            SIZE_HALF: res = {2{data[15:0]}};
            default:   res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load data extraction: selects the addressed byte/half lane of the
// returned word and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        unsigned_ld,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to access size
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = rdata;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SIZE_BYTE: data = {{24{byte_s[7] & ~unsigned_ld}}, byte_s};
            SIZE_HALF: data = {{16{half_s[15] & ~unsigned_ld}}, half_s};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes one EX result at a time, issues a data-memory
// request for loads/stores and produces a single-cycle writeback for loads and ALU results.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] store_data,
    input  logic [1:0]      mem_op,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [4:0]      rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            misalign
);

    state_e          state_r, state_s;
    mem_op_e         op_r, op_s, ex_op_s;
    mem_size_e       size_r, size_s, ex_size_s;
    logic            unsigned_r, unsigned_s;
    logic [4:0]      rd_r, rd_s;
    logic            ex_ready_r, ex_ready_s;
    logic            dmem_req_r, dmem_req_s;
    logic            dmem_we_r, dmem_we_s;
    logic [XLEN-1:0] dmem_addr_r, dmem_addr_s;
    logic [XLEN-1:0] dmem_wdata_r, dmem_wdata_s;
    logic [3:0]      dmem_wstrb_r, dmem_wstrb_s;
    logic            wb_valid_r, wb_valid_s;
    logic [XLEN-1:0] wb_data_r, wb_data_s;
    logic [4:0]      wb_rd_r, wb_rd_s;
    logic            misalign_r, misalign_s;
    logic [XLEN-1:0] load_data_s;

    assign ex_op_s   = mem_op_e'(mem_op);
    assign ex_size_s = mem_size_e'(mem_size);

    mem_load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr        (dmem_addr_r[1:0]),
        .size        (size_r),
        .unsigned_ld (unsigned_r),
        .data        (load_data_s)
    );

    // Next-state and next-output computation; pulse outputs default low
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        size_s       = size_r;
        unsigned_s   = unsigned_r;
        rd_s         = rd_r;
        dmem_req_s   = dmem_req_r;
        dmem_we_s    = dmem_we_r;
        dmem_addr_s  = dmem_addr_r;
        dmem_wdata_s = dmem_wdata_r;
        dmem_wstrb_s = dmem_wstrb_r;
        wb_valid_s   = 1'b0;
        wb_data_s    = wb_data_r;
        wb_rd_s      = wb_rd_r;
        misalign_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ex_valid) begin
                    op_s       = ex_op_s;
                    size_s     = ex_size_s;
                    unsigned_s = mem_unsigned;
                    rd_s       = rd;
                    if ((ex_op_s == MEM_LOAD) || (ex_op_s == MEM_STORE)) begin
                        if (is_misaligned(ex_size_s, alu_out[1:0])) begin
                            misalign_s = 1'b1;
                        end else begin
                            state_s      = ST_REQ;
                            dmem_req_s   = 1'b1;
                            dmem_we_s    = (ex_op_s == MEM_STORE);
                            dmem_addr_s  = alu_out;
                            dmem_wdata_s = (ex_op_s == MEM_STORE) ? store_lanes(ex_size_s, store_data) : 32'h0000_0000;
                            dmem_wstrb_s = (ex_op_s == MEM_STORE) ? store_strobe(ex_size_s, alu_out[1:0]) : 4'b0000;
                        end
                    end else begin
                        state_s    = ST_WB;
                        wb_valid_s = 1'b1;
                        wb_data_s  = alu_out;
                        wb_rd_s    = rd;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    dmem_req_s = 1'b0;
                    dmem_we_s  = 1'b0;
                    state_s    = (op_r == MEM_STORE) ? ST_IDLE : ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_s    = ST_WB;
                    wb_valid_s = 1'b1;
                    wb_data_s  = load_data_s;
                    wb_rd_s    = rd_r;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        ex_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset overrides any accept, grant or response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            op_r         <= MEM_NONE;
            size_r       <= SIZE_BYTE;
            unsigned_r   <= 1'b0;
            rd_r         <= 5'd0;
            ex_ready_r   <= 1'b1;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'h0000_0000;
            dmem_wdata_r <= 32'h0000_0000;
            dmem_wstrb_r <= 4'b0000;
            wb_valid_r   <= 1'b0;
            wb_data_r    <= 32'h0000_0000;
            wb_rd_r      <= 5'd0;
            misalign_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            size_r       <= size_s;
            unsigned_r   <= unsigned_s;
            rd_r         <= rd_s;
            ex_ready_r   <= ex_ready_s;
            dmem_req_r   <= dmem_req_s;
            dmem_we_r    <= dmem_we_s;
            dmem_addr_r  <= dmem_addr_s;
            dmem_wdata_r <= dmem_wdata_s;
            dmem_wstrb_r <= dmem_wstrb_s;
            wb_valid_r   <= wb_valid_s;
            wb_data_r    <= wb_data_s;
            wb_rd_r      <= wb_rd_s;
            misalign_r   <= misalign_s;
        end
    end

    assign ex_ready   = ex_ready_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign dmem_wstrb = dmem_wstrb_r;
    assign wb_valid   = wb_valid_r;
    assign wb_data    = wb_data_r;
    assign wb_rd      = wb_rd_r;
    assign misalign   = misalign_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks are queued at issue and
// checked whenever wb_valid is seen; handshake/strobe/misalign/reset cases checked inline.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [1:0]  mem_op = 2'b00;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_exp;
    int checks = 0;
    int failures = 0;

    mem_access_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_out(alu_out), .store_data(store_data), .mem_op(mem_op), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every writeback must match the oldest queued expectation
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_eq("wb_data", wb_data, mon_exp.data);
                check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, mon_exp.rd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
        int n;
        n = 0;
        while (ex_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("ex_ready_wait", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b1; mem_op = op; mem_size = size; mem_unsigned = uns;
        alu_out = a; store_data = sd; rd = r;
        step();
        ex_valid = 1'b0; mem_op = 2'b00; alu_out = 32'hA5A5_A5A5; store_data = 32'h5A5A_5A5A;
    endtask

    task automatic pass_through(input logic [1:0] op, input logic [31:0] a, input logic [4:0] r);
        sb_q.push_back({a, r});
        issue(op, 2'b10, 1'b0, a, 32'h0, r);
        @(negedge clk);
        check_eq("pt_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("pt_no_req", {31'd0, dmem_req}, 32'd0);
        step();
        @(negedge clk);
        check_eq("pt_one_cycle", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic do_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] sd,
                            input int gnt_delay, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        issue(2'b10, size, 1'b0, a, sd, 5'd7);
        for (int i = 0; i <= gnt_delay; i++) begin
            if (i == gnt_delay) dmem_gnt = 1'b1;
            @(negedge clk);
            check_eq("st_req", {31'd0, dmem_req}, 32'd1);
            check_eq("st_we", {31'd0, dmem_we}, 32'd1);
            check_eq("st_addr", dmem_addr, a);
            check_eq("st_wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            check_eq("st_wdata", dmem_wdata, exp_wdata);
            step();
        end
        dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("st_req_drop", {31'd0, dmem_req}, 32'd0);
        check_eq("st_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
    endtask

    task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [4:0] r, input logic [31:0] exp);
        sb_q.push_back({exp, r});
        issue(2'b01, size, uns, a, 32'h0, r);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        check_eq("ld_req", {31'd0, dmem_req}, 32'd1);
        check_eq("ld_we", {31'd0, dmem_we}, 32'd0);
        check_eq("ld_addr", dmem_addr, a);
        step();
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("ld_wait_req", {31'd0, dmem_req}, 32'd0);
        check_eq("ld_wait_nowb", {31'd0, wb_valid}, 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check_eq("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        step();
    endtask

    task automatic do_misalign(input logic [1:0] op, input logic [1:0] size, input logic [31:0] a);
        issue(op, size, 1'b0, a, 32'h1234_5678, 5'd4);
        @(negedge clk);
        check_eq("mis_flag", {31'd0, misalign}, 32'd1);
        check_eq("mis_no_req", {31'd0, dmem_req}, 32'd0);
        check_eq("mis_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        @(negedge clk);
        check_eq("mis_one_cycle", {31'd0, misalign}, 32'd0);
        check_eq("mis_no_req2", {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        @(negedge clk);
        check_eq("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rst_we", {31'd0, dmem_we}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst_addr", dmem_addr, 32'h0);
        check_eq("rst_wdata", dmem_wdata, 32'h0);
        check_eq("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        reset = 1'b0;
        step();

        // Response while idle must not produce a writeback
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_rvalid = 1'b0;

        pass_through(2'b00, 32'h0000_0005, 5'd3);
        pass_through(2'b11, 32'h1234_5678, 5'd0);
        pass_through(2'b00, 32'hFFFF_FFFF, 5'd31);

        do_store(2'b00, 32'h0000_1002, 32'h0000_00AB, 2, 4'b0100, 32'hABAB_ABAB);
        do_store(2'b01, 32'h0000_1002, 32'h1234_5678, 0, 4'b1100, 32'h5678_5678);
        do_store(2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);
        do_store(2'b00, 32'h0000_1001, 32'h1122_3344, 0, 4'b0010, 32'h4444_4444);

        do_load(2'b00, 1'b0, 32'h0000_1001, 32'h0000_8000, 5'd9, 32'hFFFF_FF80);
        do_load(2'b00, 1'b1, 32'h0000_1001, 32'h0000_8000, 5'd9, 32'h0000_0080);
        do_load(2'b01, 1'b0, 32'h0000_1002, 32'h8765_4321, 5'd10, 32'hFFFF_8765);
        do_load(2'b01, 1'b1, 32'h0000_1000, 32'h1234_F00D, 5'd11, 32'h0000_F00D);
        do_load(2'b10, 1'b0, 32'h0000_1004, 32'hCAFE_BABE, 5'd12, 32'hCAFE_BABE);
        do_load(2'b00, 1'b0, 32'h0000_1003, 32'h7F00_0000, 5'd13, 32'h0000_007F);
        do_load(2'b11, 1'b0, 32'h0000_1008, 32'h8000_0001, 5'd0, 32'h8000_0001);

        do_misalign(2'b01, 2'b01, 32'h0000_1003);
        do_misalign(2'b10, 2'b10, 32'h0000_1002);
        do_misalign(2'b01, 2'b11, 32'h0000_1001);

        // Reset while waiting for the load response, then a late response
        issue(2'b01, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 5'd5);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rwait_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rwait_ex_ready", {31'd0, ex_ready}, 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rwait_no_wb", {31'd0, wb_valid}, 32'd0);
        check_eq("rwait_ex_ready2", {31'd0, ex_ready}, 32'd1);
        step();

        // Reset in REQ dominates a simultaneous grant
        issue(2'b10, 2'b10, 1'b0, 32'h0000_4000, 32'h0BAD_F00D, 5'd6);
        @(negedge clk);
        check_eq("rreq_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        dmem_gnt = 1'b1;
        step();
        reset = 1'b0;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("rreq_req_drop", {31'd0, dmem_req}, 32'd0);
        check_eq("rreq_addr", dmem_addr, 32'h0);
        check_eq("rreq_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();

        // Reset dominates a simultaneous accept
        ex_valid = 1'b1; mem_op = 2'b00; alu_out = 32'h0000_0077; rd = 5'd8;
        reset = 1'b1;
        step();
        ex_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rdom_no_wb", {31'd0, wb_valid}, 32'd0);
        check_eq("rdom_ex_ready", {31'd0, ex_ready}, 32'd1);

        repeat (3) step();
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  EX result present this cycle.
REQ-005 SHALL have port ex_ready  output  1  stage accepts EX result this cycle.
REQ-006 SHALL have port alu_out  input  32  ALUOut from ALU; address for load/store, result otherwise.
REQ-007 SHALL have port store_data  input  32  rs2 value for stores.
REQ-008 SHALL have port mem_op  input  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-009 SHALL have port mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 SHALL have port mem_unsigned  input  1  zero-extend loads when 1.
REQ-011 SHALL have port rd  input  5  destination register.
REQ-012 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_wstrb out 4: data-memory request.
REQ-013 SHALL have ports dmem_gnt in 1 (request accepted), dmem_rvalid in 1, dmem_rdata in 32 (load response).
REQ-014 SHALL have ports wb_valid out 1, wb_data out 32, wb_rd out 5, misalign out 1.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, WB; ex_ready = 1 only in IDLE.
REQ-016 SHALL capture all inputs on ex_valid & ex_ready (accept); no capture otherwise.
REQ-017 mem_op none: IDLE->WB; wb_data = alu_out, wb_rd = rd, wb_valid = 1 for exactly one cycle (latency 1), then IDLE.
REQ-018 Load/store: IDLE->REQ; dmem_req, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb SHALL be held stable from REQ entry until dmem_gnt sampled high.
REQ-019 Store: REQ & dmem_gnt -> IDLE; wb_valid stays 0.
REQ-020 Load: REQ & dmem_gnt -> WAIT; WAIT & dmem_rvalid -> WB with extracted data; dmem_rvalid outside WAIT SHALL be ignored.
REQ-021 dmem_wstrb: byte 0001<<addr[1:0], half 0011<<(2*addr[1]), word 1111; dmem_wdata replicates the low byte/half across lanes.
REQ-022 Load extraction: byte lane addr[1:0], half lane addr[1]; sign-extend from bit 7/15 unless mem_unsigned; word passes unchanged.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no dmem_req, misalign = 1 for one cycle, wb_valid = 0, next state IDLE.
REQ-024 dmem_addr SHALL equal captured alu_out unmodified (no alignment masking).
REQ-025 wb_valid SHALL assert even when rd = 0.

Reset
REQ-026 On reset: state IDLE; ex_ready 1; dmem_req, dmem_we, wb_valid, misalign 0; dmem_addr, dmem_wdata, wb_data 0; dmem_wstrb 0000; wb_rd 0.
REQ-027 Reset in REQ/WAIT/WB SHALL abort the operation: dmem_req low and wb_valid low from the next cycle; a later dmem_rvalid SHALL be ignored.
REQ-028 Reset dominates a simultaneous accept, dmem_gnt or dmem_rvalid.

Structure
REQ-029 Shared package SHALL hold mem_op and mem_size encodings and the FSM state enum.
REQ-030 Load extraction/extension SHALL be a combinational sub-module mem_load_align (inputs rdata, addr[1:0], size, unsigned; output 32-bit data).

Verification
REQ-031 Pass-through: alu_out=0x0000_0005, mem_op=00, rd=3 -> next cycle wb_valid=1, wb_data=0x5, wb_rd=3, one cycle only.
REQ-032 Store byte: addr=0x1002, store_data=0xAB, gnt after 2 wait cycles -> wstrb=0100, wdata=0xABABABAB held 3 cycles, wb_valid never 1.
REQ-033 Load byte signed: addr=0x1001, rdata=0x0000_8000 -> wb_data=0xFFFF_FF80; same with mem_unsigned=1 -> 0x0000_0080.
REQ-034 Load half addr=0x1003 -> misalign=1 one cycle, dmem_req=0 throughout, ex_ready=1 next cycle.
REQ-035 Load word, reset asserted in WAIT, then rvalid=1 rdata=0xDEADBEEF -> wb_valid stays 0, state IDLE, ex_ready=1.
